// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : seg_pkg
// Purpose : Shared definitions for the 7-segment message engine: character
//           codes (same code space as the display decoder), display modes,
//           scroller state encoding and the preset game-status messages.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package seg_pkg;

  localparam int SEG_CHAR_W = 6;

  typedef logic [SEG_CHAR_W-1:0] char_t;

  // Numeric glyphs map directly onto their value.
  localparam char_t C_0 = 6'd0;
  localparam char_t C_1 = 6'd1;
  localparam char_t C_2 = 6'd2;
  localparam char_t C_3 = 6'd3;
  localparam char_t C_4 = 6'd4;
  localparam char_t C_5 = 6'd5;
  localparam char_t C_6 = 6'd6;
  localparam char_t C_7 = 6'd7;
  localparam char_t C_8 = 6'd8;
  localparam char_t C_9 = 6'd9;
  localparam char_t C_BLANK = 6'd10;
  // Letters follow BLANK in alphabetical order.
  localparam char_t C_A = 6'd11;
  localparam char_t C_B = 6'd12;
  localparam char_t C_C = 6'd13;
  localparam char_t C_D = 6'd14;
  localparam char_t C_E = 6'd15;
  localparam char_t C_F = 6'd16;
  localparam char_t C_G = 6'd17;
  localparam char_t C_H = 6'd18;
  localparam char_t C_I = 6'd19;
  localparam char_t C_J = 6'd20;
  localparam char_t C_K = 6'd21;
  localparam char_t C_L = 6'd22;
  localparam char_t C_M = 6'd23;
  localparam char_t C_N = 6'd24;
  localparam char_t C_O = 6'd25;
  localparam char_t C_P = 6'd26;
  localparam char_t C_Q = 6'd27;
  localparam char_t C_R = 6'd28;
  localparam char_t C_S = 6'd29;
  localparam char_t C_T = 6'd30;
  localparam char_t C_U = 6'd31;
  localparam char_t C_V = 6'd32;
  localparam char_t C_W = 6'd33;
  localparam char_t C_X = 6'd34;
  localparam char_t C_Y = 6'd35;

  // Encoding matches the 2-bit mode_in field; code 3 is reserved.
  typedef enum logic [1:0] {
    DM_STATIC = 2'd0,
    DM_SCROLL = 2'd1,
    DM_BLINK  = 2'd2
  } disp_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STATIC    = 3'd1,
    ST_SCROLL    = 3'd2,
    ST_BLINK_ON  = 3'd3,
    ST_BLINK_OFF = 3'd4
  } scr_state_t;

  // Preset messages, BLANK padded to a common length.
  localparam int PRESET_LEN = 8;
  typedef char_t preset_t [PRESET_LEN];

  localparam preset_t MSG_VICTORY = '{C_V, C_I, C_C, C_T, C_O, C_R, C_Y, C_BLANK};
  localparam int      MSG_VICTORY_LEN = 7;
  localparam preset_t MSG_LOSER = '{C_L, C_O, C_S, C_E, C_R, C_BLANK, C_BLANK, C_BLANK};
  localparam int      MSG_LOSER_LEN = 5;
  localparam preset_t MSG_TIED = '{C_T, C_I, C_E, C_D, C_BLANK, C_BLANK, C_BLANK, C_BLANK};
  localparam int      MSG_TIED_LEN = 4;
  localparam preset_t MSG_PASSQ = '{C_P, C_A, C_S, C_S, C_Q, C_BLANK, C_BLANK, C_BLANK};
  localparam int      MSG_PASSQ_LEN = 5;
  localparam preset_t MSG_ENDQ = '{C_E, C_N, C_D, C_Q, C_BLANK, C_BLANK, C_BLANK, C_BLANK};
  localparam int      MSG_ENDQ_LEN = 4;
  localparam preset_t MSG_PASSED = '{C_P, C_A, C_S, C_S, C_E, C_D, C_BLANK, C_BLANK};
  localparam int      MSG_PASSED_LEN = 6;

  // SCROLL and both BLINK phases count as an ongoing animation.
  function automatic logic is_animated(input scr_state_t s);
    return (s == ST_SCROLL) || (s == ST_BLINK_ON) || (s == ST_BLINK_OFF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_msg_scroller_tick_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tick_divider
// Purpose : Counts enabled cycles and emits a one-cycle tick on every DIV-th
//           enabled cycle. While en_in is low the count holds, so a paused
//           animation resumes exactly where it stopped.
// Ports   : clk_in   - system clock
//           rst_in   - synchronous active-high reset
//           clear_in - restart the count from zero
//           en_in    - count this cycle
//           tick_out - high on the enabled cycle that completes DIV counts
// Revision: 1.0 - initial release
// ============================================================================
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  input  logic en_in,
  output logic tick_out
);

  localparam int              CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in || clear_in) begin
      cnt_q <= '0;
    end else if (en_in) begin
      cnt_q <= (cnt_q == C_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Decoded from the registered count; gating with en_in keeps frozen
  // cycles from ever producing a step.
  assign tick_out = en_in && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_msg_scroller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : seg_msg_scroller
// Purpose : Registered message engine for the N-digit 7-segment character
//           bus. Latches a message on a load strobe and then shows it as a
//           static frame, a scrolling marquee or a blinking frame.
// Ports   : clk_in       - system clock
//           rst_in       - synchronous active-high reset
//           load_in      - one-cycle strobe latching msg_in/len_in/mode_in
//           msg_in       - character codes, index 0 = first character
//           len_in       - number of valid characters (clamped to MSG_LEN)
//           mode_in      - 0 static, 1 scroll, 2 blink, 3 treated as static
//           freeze_in    - pause animation, hold the displayed frame
//           seg_data_out - digit codes, index NUM_DIGITS-1 = leftmost
//           wrap_out     - one-cycle pulse when a scroll pass completes
//           busy_out     - high while scrolling or blinking
// Revision: 1.0 - initial release
// ============================================================================
module seg_msg_scroller
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CHAR_W     = 6,
  parameter int MSG_LEN    = 16,
  parameter int SCROLL_DIV = 25_000_000,
  parameter int BLINK_DIV  = 12_500_000
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           load_in,
  input  logic [CHAR_W-1:0]              msg_in [MSG_LEN],
  input  logic [$clog2(MSG_LEN+1)-1:0]   len_in,
  input  logic [1:0]                     mode_in,
  input  logic                           freeze_in,
  output logic [CHAR_W-1:0]              seg_data_out [NUM_DIGITS],
  output logic                           wrap_out,
  output logic                           busy_out
);

  localparam int LEN_W = $clog2(MSG_LEN + 1);
  localparam int OFF_W = $clog2(NUM_DIGITS + MSG_LEN + 1);

  localparam logic [CHAR_W-1:0] C_BLANK_W = CHAR_W'(C_BLANK);
  localparam logic [LEN_W-1:0]  C_LEN_MAX = LEN_W'(MSG_LEN);
  localparam logic [OFF_W-1:0]  C_OFF_HOME = OFF_W'(NUM_DIGITS);

  scr_state_t          state_q, state_d;
  logic [OFF_W-1:0]    offset_q, offset_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [CHAR_W-1:0]   buf_q [MSG_LEN];
  logic [CHAR_W-1:0]   buf_d [MSG_LEN];
  logic [CHAR_W-1:0]   seg_q [NUM_DIGITS];
  logic [CHAR_W-1:0]   seg_d [NUM_DIGITS];
  logic                wrap_q, wrap_d;
  logic                busy_q, busy_d;

  logic                scroll_en, scroll_tick;
  logic                blink_en, blink_tick;
  logic                frame_on;

  // Each divider runs only while its own state is active and not frozen;
  // a load restarts both so the first step is a full period after load.
  assign scroll_en = (state_q == ST_SCROLL) && !freeze_in;
  assign blink_en  = ((state_q == ST_BLINK_ON) || (state_q == ST_BLINK_OFF)) && !freeze_in;

  tick_divider #(
    .DIV (SCROLL_DIV)
  ) u_scroll_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (load_in),
    .en_in    (scroll_en),
    .tick_out (scroll_tick)
  );

  tick_divider #(
    .DIV (BLINK_DIV)
  ) u_blink_div (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (load_in),
    .en_in    (blink_en),
    .tick_out (blink_tick)
  );

  // Next-state logic. Load wins over freeze and over any pending step, so a
  // load on the wrap cycle never lets wrap_out through.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    len_d    = len_q;
    buf_d    = buf_q;
    wrap_d   = 1'b0;

    if (load_in) begin
      buf_d    = msg_in;
      len_d    = (len_in > C_LEN_MAX) ? C_LEN_MAX : len_in;
      offset_d = C_OFF_HOME;
      if (len_d == '0) begin
        state_d = ST_STATIC;
      end else begin
        case (disp_mode_t'(mode_in))
          DM_SCROLL: state_d = ST_SCROLL;
          DM_BLINK:  state_d = ST_BLINK_ON;
          default:   state_d = ST_STATIC;
        endcase
      end
    end else begin
      case (state_q)
        ST_SCROLL: begin
          if (scroll_tick) begin
            // Stepping onto NUM_DIGITS+len would give an empty screen, so
            // restart with the message entering from the right instead.
            if (int'(offset_q) + 1 >= NUM_DIGITS + int'(len_q)) begin
              offset_d = '0;
              wrap_d   = 1'b1;
            end else begin
              offset_d = offset_q + OFF_W'(1);
            end
          end
        end
        ST_BLINK_ON: begin
          if (blink_tick) state_d = ST_BLINK_OFF;
        end
        ST_BLINK_OFF: begin
          if (blink_tick) state_d = ST_BLINK_ON;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Frame builder, evaluated on next-state values so the registered output
  // lines up with the state change. Static and blink-on frames reuse the
  // scroll window parked at offset NUM_DIGITS (left-justified message).
  // Digit k shows tape[offset+NUM_DIGITS-1-k]; the leading NUM_DIGITS tape
  // cells are blank, so the message index is offset-1-k.
  assign frame_on = (state_d == ST_STATIC) || (state_d == ST_SCROLL) ||
                    (state_d == ST_BLINK_ON);

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg_d[k] = C_BLANK_W;
      if (frame_on) begin
        for (int j = 0; j < MSG_LEN; j++) begin
          if ((j == int'(offset_d) - 1 - k) && (j < int'(len_d))) begin
            seg_d[k] = buf_d[j];
          end
        end
      end
    end
  end

  assign busy_d = is_animated(state_d);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      offset_q <= '0;
      len_q    <= '0;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < MSG_LEN; i++) begin
        buf_q[i] <= C_BLANK_W;
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
        seg_q[k] <= C_BLANK_W;
      end
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      len_q    <= len_d;
      wrap_q   <= wrap_d;
      busy_q   <= busy_d;
      buf_q    <= buf_d;
      seg_q    <= seg_d;
    end
  end

  assign seg_data_out = seg_q;
  assign wrap_out     = wrap_q;
  assign busy_out     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_msg_scroller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_seg_msg_scroller
// Purpose : Self-checking bench for seg_msg_scroller with a 4-digit display,
//           8-character buffer, scroll step of 4 cycles and blink half-period
//           of 3 cycles. Expected frames are queued as stimulus is applied
//           and popped after each clock edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_msg_scroller;

  localparam int ND = 4;
  localparam int CW = 6;
  localparam int ML = 8;
  localparam int SD = 4;
  localparam int BD = 3;
  localparam int LW = $clog2(ML + 1);

  typedef logic [CW-1:0]   ch_t;
  typedef ch_t [ND-1:0]    frame_t;
  typedef ch_t [ML-1:0]    msg_t;
  typedef struct packed {
    frame_t frame;
    logic   wrap;
    logic   busy;
  } exp_t;

  logic          clk;
  logic          rst_in;
  logic          load_in;
  ch_t           msg_in [ML];
  logic [LW-1:0] len_in;
  logic [1:0]    mode_in;
  logic          freeze_in;
  ch_t           seg_out [ND];
  logic          wrap;
  logic          busy;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];

  seg_msg_scroller #(
    .NUM_DIGITS (ND),
    .CHAR_W     (CW),
    .MSG_LEN    (ML),
    .SCROLL_DIV (SD),
    .BLINK_DIV  (BD)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .load_in      (load_in),
    .msg_in       (msg_in),
    .len_in       (len_in),
    .mode_in      (mode_in),
    .freeze_in    (freeze_in),
    .seg_data_out (seg_out),
    .wrap_out     (wrap),
    .busy_out     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- model and stimulus helpers ----------------
  function automatic msg_t mk_msg(input int c0, c1, c2, c3, c4, c5, c6, c7);
    msg_t m;
    m[0] = ch_t'(c0); m[1] = ch_t'(c1); m[2] = ch_t'(c2); m[3] = ch_t'(c3);
    m[4] = ch_t'(c4); m[5] = ch_t'(c5); m[6] = ch_t'(c6); m[7] = ch_t'(c7);
    return m;
  endfunction

  // Arguments in display order: leftmost digit first.
  function automatic frame_t mk_frame(input int d3, d2, d1, d0);
    frame_t f;
    f[3] = ch_t'(d3); f[2] = ch_t'(d2); f[1] = ch_t'(d1); f[0] = ch_t'(d0);
    return f;
  endfunction

  // Tape = ND blanks, then message, then blanks; digit k shows tape[off+ND-1-k].
  function automatic frame_t model_frame(input msg_t m, input int len, input int off, input bit on);
    frame_t f;
    for (int k = 0; k < ND; k++) begin
      int t;
      t = off + ND - 1 - k;
      f[k] = ch_t'(10);
      if (on && t >= ND && (t - ND) < len) f[k] = m[t - ND];
    end
    return f;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    for (int k = 0; k < ND; k++) o.frame[k] = seg_out[k];
    o.wrap = wrap;
    o.busy = busy;
    return o;
  endfunction

  task automatic apply_load(input logic [1:0] mode, input int len, input msg_t m);
    for (int i = 0; i < ML; i++) msg_in[i] = m[i];
    len_in  = LW'(len);
    mode_in = mode;
    load_in = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    exp_t x, e, got;
    msg_t m;
    rst_in = 1'b1; load_in = 1'b0; freeze_in = 1'b0; mode_in = 2'd0; len_in = '0;
    for (int i = 0; i < ML; i++) msg_in[i] = ch_t'(0);
    x.frame = mk_frame(10, 10, 10, 10); x.wrap = 1'b0; x.busy = 1'b0;
    sb_q.push_back(x);
    tick(); tick();
    rst_in = 1'b0;
    got = observe(); e = sb_q.pop_front(); tests_run++;
    if (got !== e) begin tests_failed++; $display("FAIL reset_power_on: got %h expected %h", got, e); end

    // Start scrolling, then reset for two cycles mid-animation.
    m = mk_msg(11, 12, 13, 14, 15, 10, 10, 10);
    apply_load(2'd1, 5, m);
    tick(); load_in = 1'b0;
    repeat (6) tick();
    rst_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sb_q.push_back(x);
      tick();
      if (c == 1) rst_in = 1'b0;
      got = observe(); e = sb_q.pop_front(); tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL reset_mid_scroll c=%0d: got %h expected %h", c, got, e); end
    end
  endtask

  task automatic test_static();
    exp_t x, e, got;
    msg_t m;
    m = mk_msg(26, 11, 29, 29, 10, 10, 10, 10);
    for (int c = 0; c <= 50; c++) begin
      if (c == 0) apply_load(2'd0, 4, m);
      x.frame = mk_frame(26, 11, 29, 29); x.wrap = 1'b0; x.busy = 1'b0;
      sb_q.push_back(x);
      tick(); load_in = 1'b0;
      got = observe(); e = sb_q.pop_front(); tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL static_pass c=%0d: got %h expected %h", c, got, e); end
    end
    // Reserved mode 3 behaves as static.
    m = mk_msg(30, 19, 15, 14, 10, 10, 10, 10);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) apply_load(2'd3, 4, m);
      x.frame = mk_frame(30, 19, 15, 14); x.wrap = 1'b0; x.busy = 1'b0;
      sb_q.push_back(x);
      tick(); load_in = 1'b0;
      got = observe(); e = sb_q.pop_front(); tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL static_mode3 c=%0d: got %h expected %h", c, got, e); end
    end
  endtask

  task automatic test_scroll();
    exp_t x, e, got;
    msg_t m;
    frame_t f;
    int off, wraps;
    m = mk_msg(11, 12, 13, 14, 15, 10, 10, 10);
    off = ND; wraps = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 0) apply_load(2'd1, 5, m);
      x.wrap = 1'b0;
      if (c > 0 && c % SD == 0) begin
        if (off + 1 == ND + 5) begin off = 0; x.wrap = 1'b1; end
        else off++;
      end
      x.frame = model_frame(m, 5, off, 1'b1); x.busy = 1'b1;
      sb_q.push_back(x);
      tick(); load_in = 1'b0;
      got = observe(); e = sb_q.pop_front(); tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL scroll c=%0d: got %h expected %h", c, got, e); end
      if (got.wrap) wraps++;
      if (c == 0 || c == 4 || c == 8 || c == 20 || c == 24) begin
        case (c)
          0:       f = mk_frame(11, 12, 13, 14);
          4:       f = mk_frame(12, 13, 14, 15);
          8:       f = mk_frame(13, 14, 15, 10);
          20:      f = mk_frame(10, 10, 10, 10);
          default: f = mk_frame(10, 10, 10, 11);
        endcase
        tests_run++;
        if (got.frame !== f) begin tests_failed++; $display("FAIL scroll_frame c=%0d: got %h expected %h", c, got.frame, f); end
      end
    end
    tests_run++;
    if (wraps != 2) begin tests_failed++; $display("FAIL scroll_wrap_count: got %0d expected 2", wraps); end
  endtask

  task automatic test_clamp();
    exp_t x, e, got;
    msg_t m;
    int off;
    // len_in = 15 exceeds the 8-character buffer and clamps to 8.
    m = mk_msg(11, 12, 13, 14, 15, 16, 17, 18);
    off = ND;
    for (int c = 0; c < 36; c++) begin
      if (c == 0) apply_load(2'd1, 15, m);
      x.wrap = 1'b0;
      if (c > 0 && c % SD == 0) begin
        if (off + 1 == ND + ML) begin off = 0; x.wrap = 1'b1; end
        else off++;
      end
      x.frame = model_frame(m, ML, off, 1'b1); x.busy = 1'b1;
      sb_q.push_back(x);
      tick(); load_in = 1'b0;
      got = observe(); e = sb_q.pop_front(); tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL clamp_scroll c=%0d: got %h expected %h", c, got, e); end
    end
  endtask

  task automatic test_blink();
    exp_t x, e, got;
    msg_t m;
    m = mk_msg(30, 19, 15, 14, 10, 10, 10, 10);
    for (int c = 0; c < 12; c++) begin
      if (c == 0) apply_load(2'd2, 4, m);
      x.frame = (((c / BD) % 2) == 0) ? mk_frame(30, 19, 15, 14) : mk_frame(10, 10, 10, 10);
      x.wrap = 1'b0; x.busy = 1'b1;
      sb_q.push_back(x);
      tick(); load_in = 1'b0;
      got = observe(); e = sb_q.pop_front(); tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL blink c=%0d: got %h expected %h", c, got, e); end
    end
  endtask

  task automatic test_freeze();
    exp_t x, e, got;
    msg_t m;
    int off, act;
    bit frz;
    m = mk_msg(11, 12, 13, 14, 15, 10, 10, 10);
    off = ND; act = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 0) apply_load(2'd1, 5, m);
      frz = (c >= 6 && c <= 15);
      freeze_in = frz;
      x.wrap = 1'b0;
      if (c > 0 && !frz) begin
        act++;
        if (act % SD == 0) begin
          if (off + 1 == ND + 5) begin off = 0; x.wrap = 1'b1; end
          else off++;
        end
      end
      x.frame = model_frame(m, 5, off, 1'b1); x.busy = 1'b1;
      sb_q.push_back(x);
      tick(); load_in = 1'b0;
      got = observe(); e = sb_q.pop_front(); tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL freeze c=%0d: got %h expected %h", c, got, e); end
      // Count stood at 1 of 4 when frozen: step lands 3 cycles after release.
      if (c == 17 || c == 18) begin
        tests_run++;
        if (got.frame !== ((c == 17) ? mk_frame(12, 13, 14, 15) : mk_frame(13, 14, 15, 10))) begin
          tests_failed++;
          $display("FAIL freeze_resume c=%0d: got %h", c, got.frame);
        end
      end
    end
    freeze_in = 1'b0;
  endtask

  task automatic test_load_on_wrap();
    exp_t x, e, got;
    msg_t m;
    int off;
    m = mk_msg(11, 12, 13, 14, 15, 10, 10, 10);
    off = ND;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) apply_load(2'd1, 5, m);
      if (c == 20) apply_load(2'd1, 0, m);
      if (c < 20) begin
        if (c > 0 && c % SD == 0) off++;
        x.frame = model_frame(m, 5, off, 1'b1); x.wrap = 1'b0; x.busy = 1'b1;
      end else begin
        x.frame = mk_frame(10, 10, 10, 10); x.wrap = 1'b0; x.busy = 1'b0;
      end
      sb_q.push_back(x);
      tick(); load_in = 1'b0;
      got = observe(); e = sb_q.pop_front(); tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL load_on_wrap c=%0d: got %h expected %h", c, got, e); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x, e, got;
    msg_t m_pass, m_tied;
    m_pass = mk_msg(26, 11, 29, 29, 10, 10, 10, 10);
    m_tied = mk_msg(30, 19, 15, 14, 10, 10, 10, 10);
    for (int c = 0; c < 10; c++) begin
      if (c == 0) apply_load(2'd0, 4, m_pass);
      if (c == 1) apply_load(2'd2, 4, m_tied);
      if (c == 0) begin
        x.frame = mk_frame(26, 11, 29, 29); x.busy = 1'b0;
      end else begin
        x.frame = ((((c - 1) / BD) % 2) == 0) ? mk_frame(30, 19, 15, 14) : mk_frame(10, 10, 10, 10);
        x.busy = 1'b1;
      end
      x.wrap = 1'b0;
      sb_q.push_back(x);
      tick(); load_in = 1'b0;
      got = observe(); e = sb_q.pop_front(); tests_run++;
      if (got !== e) begin tests_failed++; $display("FAIL back_to_back c=%0d: got %h expected %h", c, got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_scroll();
    test_clamp();
    test_blink();
    test_freeze();
    test_load_on_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
